instr_fetch_unit: RTL and testbench

//  Upstream feeder for simple_proc: replaces the manual SW[8:0] input with a small

---
 rtl/instr_fetch_unit_pkg.sv | 29 ++
 rtl/instr_fetch_unit_prog_mem.sv | 27 ++
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared opcodes, tick phases and fetch state type
package instr_fetch_unit_pkg;

  localparam int OP_W = 3;

  // Opcodes that matter to the fetcher: HALT stops fetching, MOVI/ADDI carry an immediate word
  localparam logic [OP_W-1:0] OP_HALT = 3'b000;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b010;
  localparam logic [OP_W-1:0] OP_MOVI = 3'b111;

  // One-hot slot phases produced by the shared tick generator
  localparam logic [3:0] T1 = 4'b0001;
  localparam logic [3:0] T2 = 4'b0010;
  localparam logic [3:0] T3 = 4'b0100;
  localparam logic [3:0] T4 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  // True for opcodes followed by an immediate word in the program
  function automatic logic op_has_imm(input logic [OP_W-1:0] op);
    return (op == OP_MOVI) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_prog_mem.sv
// rtl/instr_fetch_unit_prog_mem.sv - program store, synchronous write, asynchronous read
module instr_fetch_unit_prog_mem #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int WORD_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  // Contents survive reset so a program can be rerun after rst
  logic [WORD_W-1:0] mem [DEPTH];

  // Single-cycle write port used by the loader
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - slot-synchronous program fetcher driving the processor din
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int WORD_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        tick,
  input  logic              start,
  input  logic              stop,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  output logic [WORD_W-1:0] din,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              halted,
  output logic              imm_phase
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [WORD_W-1:0] din_n;
  logic [OP_W-1:0]   cur_op, cur_op_n;
  logic              imm_n;
  logic              stop_pend, stop_n;
  logic              mem_we;
  logic              slot_fetch;
  logic [WORD_W-1:0] rd_word;
  logic [OP_W-1:0]   rd_op;

  // The program store is only ever read at pc; loads go through the idle-gated write port
  instr_fetch_unit_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rd_word)
  );

  assign rd_op = rd_word[WORD_W-1 -: OP_W];

  // Next-state decode: control pulses, slot-start fetch at T1, immediate at T2, slot close at T4
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    din_n      = din;
    cur_op_n   = cur_op;
    imm_n      = imm_phase;
    stop_n     = stop_pend;
    mem_we     = 1'b0;
    slot_fetch = 1'b0;

    case (state)
      ST_IDLE, ST_HALTED: begin
        stop_n = 1'b0;
        mem_we = prog_we;
        // stop in the same cycle as start cancels it
        if (start && !stop) begin
          state_n = ST_ARM;
        end
      end

      ST_ARM: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (tick == T1) begin
          slot_fetch = 1'b1;
        end
      end

      ST_RUN: begin
        // A stop arriving anywhere in the slot is held until the slot completes
        if (stop) begin
          stop_n = 1'b1;
        end
        case (tick)
          T1: slot_fetch = 1'b1;
          T2: begin
            if (op_has_imm(cur_op)) begin
              din_n = rd_word;
              pc_n  = pc + ADDR_W'(1);
              imm_n = 1'b1;
            end
          end
          T3: ;
          T4: begin
            imm_n = 1'b0;
            if (stop || stop_pend) begin
              state_n = ST_IDLE;
              din_n   = '0;
              stop_n  = 1'b0;
            end
          end
          default: ;
        endcase
      end

      default: state_n = ST_IDLE;
    endcase

    // A HALT marker leaves pc on the marker so the program can be inspected or patched
    if (slot_fetch) begin
      if (rd_op == OP_HALT) begin
        din_n   = '0;
        state_n = ST_HALTED;
        stop_n  = 1'b0;
      end else begin
        din_n    = rd_word;
        cur_op_n = rd_op;
        pc_n     = pc + ADDR_W'(1);
        state_n  = ST_RUN;
      end
    end
  end

  // State and datapath registers; rst abandons any partial instruction immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      din       <= '0;
      cur_op    <= OP_HALT;
      imm_phase <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      din       <= din_n;
      cur_op    <= cur_op_n;
      imm_phase <= imm_n;
      stop_pend <= stop_n;
    end
  end

  assign running = (state == ST_ARM) || (state == ST_RUN);
  assign halted  = (state == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int WW    = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    tick = 4'b0000;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [WW-1:0] prog_data = '0;
  logic [WW-1:0] din;
  logic [AW-1:0] pc;
  logic          running;
  logic          halted;
  logic          imm_phase;

  instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(AW), .WORD_W(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .din       (din),
    .pc        (pc),
    .running   (running),
    .halted    (halted),
    .imm_phase (imm_phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] din;
    logic [AW-1:0] pc;
    logic          running;
    logic          halted;
    logic          imm;
  } obs_t;

  obs_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the machine as a sequence of instruction slots over a word array
  typedef enum int {M_IDLE, M_ARM, M_RUN, M_HALTED} mode_t;
  mode_t m_mode;
  int    m_pc, m_din, m_len;
  bit    m_imm, m_stop;
  int    m_prog[DEPTH];
  int    ph_idx = 0;

  function automatic void model_reset();
    m_mode = M_IDLE; m_pc = 0; m_din = 0; m_len = 1; m_imm = 0; m_stop = 0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.din     = WW'(m_din);
    o.pc      = AW'(m_pc);
    o.running = (m_mode == M_ARM) || (m_mode == M_RUN);
    o.halted  = (m_mode == M_HALTED);
    o.imm     = m_imm;
    return o;
  endfunction

  function automatic void model_slot();
    int w, op;
    w  = m_prog[m_pc];
    op = w / 64;
    if (op == 0) begin
      m_din = 0; m_mode = M_HALTED; m_stop = 0;
    end else begin
      m_din  = w;
      m_len  = (op == 7 || op == 2) ? 2 : 1;
      m_pc   = (m_pc + 1) % DEPTH;
      m_mode = M_RUN;
    end
  endfunction

  function automatic void model_step(input bit s, input bit p, input bit we, input int a, input int d,
                                     input logic [3:0] tk);
    int phase;
    case (tk)
      4'b0001: phase = 1;
      4'b0010: phase = 2;
      4'b0100: phase = 3;
      4'b1000: phase = 4;
      default: phase = 0;
    endcase
    case (m_mode)
      M_IDLE, M_HALTED: begin
        m_stop = 0;
        if (we) m_prog[a] = d;
        if (s && !p) m_mode = M_ARM;
      end
      M_ARM: begin
        if (p) m_mode = M_IDLE;
        else if (phase == 1) model_slot();
      end
      default: begin
        if (p) m_stop = 1;
        if (phase == 1) model_slot();
        else if (phase == 2 && m_len == 2) begin
          m_din = m_prog[m_pc]; m_pc = (m_pc + 1) % DEPTH; m_imm = 1;
        end else if (phase == 4) begin
          m_imm = 0;
          if (m_stop) begin m_mode = M_IDLE; m_din = 0; m_stop = 0; end
        end
      end
    endcase
  endfunction

  // Monitor: every cycle the DUT presents a registered output set; compare with the queued expectation
  always @(negedge clk) begin
    obs_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("din", int'(din), int'(e.din));
      check("pc", int'(pc), int'(e.pc));
      check("running", int'(running), int'(e.running));
      check("halted", int'(halted), int'(e.halted));
      check("imm_phase", int'(imm_phase), int'(e.imm));
    end
  end

  function automatic logic [3:0] next_tick();
    logic [3:0] t;
    t = 4'b0001 << ph_idx;
    ph_idx = (ph_idx + 1) % 4;
    return t;
  endfunction

  task automatic drive(input bit s, input bit p, input bit we, input int a, input int d, input logic [3:0] tk);
    @(negedge clk);
    rst = 1'b0; start = s; stop = p; prog_we = we;
    prog_addr = AW'(a); prog_data = WW'(d); tick = tk;
    model_step(s, p, we, a, d, tk);
    @(posedge clk);
    #1;
    sb.push_back(model_obs());
    start = 1'b0; stop = 1'b0; prog_we = 1'b0; tick = 4'b0000;
  endtask

  task automatic cyc(input bit s, input bit p, input bit we, input int a, input int d);
    drive(s, p, we, a, d, next_tick());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic load(input int a, input int d);
    cyc(0, 0, 1, a, d);
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    if (check_now) begin
      check("async_rst_din", int'(din), 0);
      check("async_rst_pc", int'(pc), 0);
      check("async_rst_running", int'(running), 0);
      check("async_rst_halted", int'(halted), 0);
      check("async_rst_imm", int'(imm_phase), 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    sb.push_back(model_obs());
  endtask

  // Advance until the model is running and the next tick driven will be phase k
  task automatic run_to(input int k);
    int n = 0;
    while (!(m_mode == M_RUN && ph_idx + 1 == k) && n < 64) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    if (n >= 64) begin
      checks++; errors++;
      $display("FAIL run_to: got timeout expected phase %0d while running", k);
    end
  endtask

  initial begin
    int n;
    logic [3:0] tk;
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_prog[i] = 0;
    @(posedge clk);
    #1;
    sb.push_back(model_obs());

    for (int i = 0; i < DEPTH; i++) load(i, 0);

    // movi with immediate, then HALT
    load(0, 'h1C0); load(1, 'h005); load(2, 'h000);
    cyc(1, 0, 0, 0, 0);
    idle(12);

    // single-word add, then HALT
    do_reset(1);
    load(0, 'h04A); load(1, 'h000);
    cyc(1, 0, 0, 0, 0);
    idle(12);

    // addi at the last address takes its immediate from address 0
    do_reset(0);
    for (int i = 0; i < DEPTH - 1; i++) load(i, 'h04A);
    load(31, 'h083);
    cyc(1, 0, 0, 0, 0);
    n = 0;
    while (m_pc != 31 && n < 300) begin cyc(0, 0, 0, 0, 0); n++; end
    cyc(0, 1, 0, 0, 0);
    while (m_mode != M_IDLE && n < 320) begin cyc(0, 0, 0, 0, 0); n++; end
    if (n >= 320) begin checks++; errors++; $display("FAIL wrap_setup: got timeout expected idle at pc 31"); end
    load(0, 'h003);
    cyc(1, 0, 0, 0, 0);
    idle(14);

    // stop at T2 of a movi slot still delivers the immediate, then resume
    do_reset(0);
    load(0, 'h1C0); load(1, 'h005); load(2, 'h04A); load(3, 'h000);
    cyc(1, 0, 0, 0, 0);
    run_to(2);
    cyc(0, 1, 0, 0, 0);
    idle(6);
    cyc(1, 0, 0, 0, 0);
    idle(12);

    // reset in T3 of an addi slot, then rerun from address 0
    do_reset(0);
    load(0, 'h091); load(1, 'h003); load(2, 'h000);
    cyc(1, 0, 0, 0, 0);
    run_to(3);
    do_reset(1);
    cyc(1, 0, 0, 0, 0);
    idle(12);

    // writes while running are dropped; start+stop together is ignored
    do_reset(0);
    load(0, 'h04A); load(1, 'h04A); load(2, 'h000);
    cyc(1, 0, 0, 0, 0);
    run_to(3);
    cyc(0, 0, 1, 0, 'h1C0);
    idle(12);
    do_reset(0);
    cyc(1, 1, 0, 0, 0);
    idle(6);
    cyc(1, 0, 0, 0, 0);
    idle(12);

    // randomized program and control traffic, including non-one-hot ticks
    do_reset(0);
    for (int i = 0; i < DEPTH; i++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(64, 511);
      load(i, w);
    end
    for (int it = 0; it < 500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 19))
        0: tk = 4'b0000;
        1: tk = 4'b0011;
        default: tk = next_tick();
      endcase
      if ($urandom_range(0, 199) == 0) do_reset(0);
      else drive(r < 8, r >= 8 && r < 13, $urandom_range(0, 3) == 0,
                 $urandom_range(0, DEPTH - 1), $urandom_range(0, 511), tk);
    end

    n = 0;
    while (sb.size() > 0 && n < 10) begin @(negedge clk); n++; end
    if (sb.size() > 0) begin checks++; errors++; $display("FAIL drain: got %0d pending expected 0", sb.size()); end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
